score_keeper: RTL
=================

Name: score_keeper

Overview:
- Upstream feeder for the 4-digit seven-segment display driver.
- Accumulates the player's score as 4-digit packed BCD from per-note judgement pulses (perfect / good / miss) issued by the game logic.
- Tracks a combo count and a score multiplier derived from it.
- Presents a glitch-free 16-bit `digits` word that changes only on commit, so the display never shows a partial sum.

Parameters:
- PERFECT_PTS, 8'h05, base points for a perfect hit, 2-digit BCD.
- GOOD_PTS, 8'h02, base points for a good hit, 2-digit BCD.
- X2_COMBO, 10, combo count (binary) at which the multiplier becomes 2.
- X4_COMBO, 20, combo count (binary) at which the multiplier becomes 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear pulse from the game FSM (new game).
- hit_perfect  in  1  one-cycle pulse.
- hit_good  in  1  one-cycle pulse.
- miss  in  1  one-cycle pulse.
- digits  out  16  score BCD: [15:12] thousands … [3:0] units; feeds the display driver.
- ready  out  1  high when IDLE and an event can be accepted.
- combo  out  7  current combo, binary, saturates at 99.
- mult  out  3  current multiplier: 1, 2 or 4.
- saturated  out  1  sticky; score has clamped at 9999.
- dropped  out  1  one-cycle pulse; a hit was ignored because ready=0.

Behaviour:
- Reset (rst=0, async):
  - digits=16'h0000, combo=0, mult=1, saturated=0, dropped=0.
  - state=IDLE, so ready=1.
- mult is combinational from combo: combo<X2_COMBO → 1; combo<X4_COMBO → 2; else 4.
- ready = (state==IDLE).
- Event priority within one cycle: clear > miss > hit_perfect > hit_good. Lower-priority events in the same cycle are discarded without pulsing dropped.
- clear: in any state, on the next edge:
  - digits=0, combo=0, saturated=0; state→IDLE.
  - Any in-progress add is aborted; its result is never committed.
- miss: combo←0 on the edge, in any state. No score change. Never dropped.
- Hit accepted only when ready=1. On the sampling edge:
  - addend←PERFECT_PTS or GOOD_PTS (upper two digits zero).
  - passes←mult, using combo before the increment.
  - work←digits, idx←0, carry←0.
  - combo←min(combo+1, 99).
  - state→ADD.
  - If saturated=1, the hit is accepted: combo updates, but state stays IDLE and the score is unchanged.
- Hit with ready=0: ignored (combo unchanged); dropped=1 for one cycle.
- ADD state: one BCD digit per cycle.
  - s = work[idx] + addend[idx] + carry; if s>9 then s−10 with carry=1, else carry=0.
  - work[idx]←s; idx++.
- After idx=3:
  - carry out = 1 → digits←16'h9999, saturated←1, state→IDLE.
  - Else passes−1. If passes now 0 → digits←work, state→IDLE. Otherwise idx←0, carry←0, stay in ADD for the next pass.
- Latency: digits updates exactly 4×mult edges after the event-sampling edge (4, 8 or 16). ready is low for that whole window.
- digits never holds an intermediate value. work is internal only.

Test Plan:
- Reset, then one hit_perfect → ready low for 4 cycles, then digits=16'h0005, combo=1, mult=1.
- 11 hit_perfect, each issued when ready → after the 10th, digits=16'h0050 and mult=2. 11th takes 8 cycles; digits=16'h0060.
- 20 perfects total → digits=16'h0150 (BCD carries through the tens and hundreds digits), mult=4. Next hit_good → digits=16'h0158 after 16 cycles.
- miss asserted together with hit_perfect → combo=0, mult=1, digits unchanged. A following hit_good gives +2.
- hit_good pulsed 2 cycles after an accepted perfect (ready=0) → dropped pulses once. Final score reflects only the perfect; combo advanced by 1 only.
- Override PERFECT_PTS=8'h99 and hit repeatedly → digits=16'h9999, saturated=1. Further hits leave digits at 9999. clear mid-ADD → digits=0, saturated=0, ready=1 on the next cycle.

Source files
------------

// File: rtl/score_keeper_if.sv
// score_keeper_if: judgement pulses in, BCD score and combo status out
interface score_keeper_if;
  logic        clear;
  logic        hit_perfect;
  logic        hit_good;
  logic        miss;
  logic [15:0] digits;
  logic        ready;
  logic [6:0]  combo;
  logic [2:0]  mult;
  logic        saturated;
  logic        dropped;
  modport master (
    output clear, hit_perfect, hit_good, miss,
    input  digits, ready, combo, mult, saturated, dropped
  );
  modport slave (
    input  clear, hit_perfect, hit_good, miss,
    output digits, ready, combo, mult, saturated, dropped
  );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: BCD score accumulator with combo multiplier, one digit added per cycle
module score_keeper #(
  parameter logic [7:0] PERFECT_PTS = 8'h05,
  parameter logic [7:0] GOOD_PTS    = 8'h02,
  parameter int         X2_COMBO    = 10,
  parameter int         X4_COMBO    = 20
) (
  input  logic clk,
  input  logic rst,
  score_keeper_if.slave sk
);
  typedef enum logic {IDLE, ADD} state_t;
  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d, work_q, work_d;
  logic [7:0]  addend_q, addend_d;
  logic [1:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic [2:0]  passes_q, passes_d;
  logic [6:0]  combo_q, combo_d, combo_inc;
  logic        saturated_q, saturated_d, dropped_q, dropped_d;
  logic [2:0]  mult_c;
  logic [3:0]  w_dig, a_dig, s_dig;
  logic [4:0]  sum;
  logic        c_out, hit;
  assign hit       = sk.hit_perfect | sk.hit_good;
  assign mult_c    = combo_q < 7'(X2_COMBO) ? 3'd1 : combo_q < 7'(X4_COMBO) ? 3'd2 : 3'd4;
  assign combo_inc = combo_q == 7'd99 ? 7'd99 : combo_q + 7'd1;
  assign w_dig     = work_q[{idx_q, 2'b00} +: 4];
  assign a_dig     = idx_q[1] ? 4'd0 : addend_q[{idx_q[0], 2'b00} +: 4];
  assign sum       = {1'b0, w_dig} + {1'b0, a_dig} + {4'd0, carry_q};
  assign c_out     = sum > 5'd9;
  assign s_dig     = c_out ? 4'(sum - 5'd10) : sum[3:0];
  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    work_d      = work_q;
    addend_d    = addend_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    passes_d    = passes_q;
    combo_d     = combo_q;
    saturated_d = saturated_q;
    dropped_d   = 1'b0;
    if (sk.clear) begin
      state_d     = IDLE;
      digits_d    = 16'h0000;
      combo_d     = 7'd0;
      saturated_d = 1'b0;
    end else begin
      if (sk.miss) combo_d = 7'd0;
      else if (hit && state_q == IDLE) begin
        combo_d = combo_inc;
        if (!saturated_q) begin
          addend_d = sk.hit_perfect ? PERFECT_PTS : GOOD_PTS;
          passes_d = mult_c;
          work_d   = digits_q;
          idx_d    = 2'd0;
          carry_d  = 1'b0;
          state_d  = ADD;
        end
      end else if (hit) dropped_d = 1'b1;
      if (state_q == ADD) begin
        for (int i = 0; i < 4; i++) if (idx_q == 2'(i)) work_d[4*i +: 4] = s_dig;
        idx_d   = idx_q + 2'd1;
        carry_d = c_out;
        // a carry out of the thousands digit means the score overflowed 9999
        if (idx_q == 2'd3) begin
          if (c_out) begin
            digits_d    = 16'h9999;
            saturated_d = 1'b1;
            state_d     = IDLE;
          end else begin
            passes_d = passes_q - 3'd1;
            if (passes_q == 3'd1) begin
              digits_d = {s_dig, work_q[11:0]};
              state_d  = IDLE;
            end
          end
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      digits_q    <= 16'h0000;
      work_q      <= 16'h0000;
      addend_q    <= 8'h00;
      idx_q       <= 2'd0;
      carry_q     <= 1'b0;
      passes_q    <= 3'd0;
      combo_q     <= 7'd0;
      saturated_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      work_q      <= work_d;
      addend_q    <= addend_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      passes_q    <= passes_d;
      combo_q     <= combo_d;
      saturated_q <= saturated_d;
      dropped_q   <= dropped_d;
    end
  end
  assign sk.digits    = digits_q;
  assign sk.ready     = state_q == IDLE;
  assign sk.combo     = combo_q;
  assign sk.mult      = mult_c;
  assign sk.saturated = saturated_q;
  assign sk.dropped   = dropped_q;
endmodule
